// File: rtl/oam_scan.sv
// Mode-2 OAM search: walks every OAM entry at two cycles per entry and keeps up to
// MAX_SPRITES entries whose vertical span covers the latched scanline, in OAM order.
module oam_scan #(
   parameter int unsigned NUM_ENTRIES = 40,
   parameter int unsigned MAX_SPRITES = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       lcd_en,
   input  logic       start,
   input  logic [7:0] ly,
   input  logic       obj_tall,
   output logic [7:0] oam_addr,
   input  logic [7:0] oam_rdata,
   output logic       busy,
   output logic       done,
   output logic [3:0] sprite_count,
   input  logic [3:0] slot_sel,
   output logic [5:0] slot_oam_idx,
   output logic [7:0] slot_x,
   output logic [3:0] slot_row
);

   typedef enum logic [1:0] {
      StIdle,
      StReadY,
      StReadX,
      StDone
   } state_e;

   state_e     state_q, state_d;
   logic [5:0] idx_q, idx_d;
   logic [7:0] ly_q, ly_d;
   logic       tall_q, tall_d;
   logic [7:0] y_q, y_d;
   logic [3:0] count_q, count_d;
   logic       wr_en;

   logic [5:0] slot_idx_q [MAX_SPRITES];
   logic [7:0] slot_x_q   [MAX_SPRITES];
   logic [3:0] slot_row_q [MAX_SPRITES];

   logic [8:0] line_pos;
   logic [8:0] y_top;
   logic [8:0] y_end;
   logic       hit;
   logic [3:0] row;

   // Nine-bit compare so that Y+H and LY+16 never wrap.
   assign line_pos = {1'b0, ly_q} + 9'd16;
   assign y_top    = {1'b0, y_q};
   assign y_end    = y_top + (tall_q ? 9'd16 : 9'd8);
   assign hit      = (line_pos >= y_top) && (line_pos < y_end);
   // The +16 vanishes modulo 16, so only the low nibbles matter for the row.
   assign row      = ly_q[3:0] - y_q[3:0];

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ly_d    = ly_q;
      tall_d  = tall_q;
      y_d     = y_q;
      count_d = count_q;
      wr_en   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               ly_d    = ly;
               tall_d  = obj_tall;
               count_d = 4'd0;
               idx_d   = 6'd0;
               state_d = StReadY;
            end
         end
         StReadY: begin
            y_d     = oam_rdata;
            state_d = StReadX;
         end
         StReadX: begin
            if (hit && (count_q < 4'(MAX_SPRITES))) begin
               wr_en   = 1'b1;
               count_d = count_q + 4'd1;
            end
            if (idx_q == 6'(NUM_ENTRIES - 1)) begin
               state_d = StDone;
            end else begin
               idx_d   = idx_q + 6'd1;
               state_d = StReadY;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      if (!lcd_en) begin
         state_d = StIdle;
         count_d = 4'd0;
         wr_en   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         idx_q   <= 6'd0;
         ly_q    <= 8'd0;
         tall_q  <= 1'b0;
         y_q     <= 8'd0;
         count_q <= 4'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ly_q    <= ly_d;
         tall_q  <= tall_d;
         y_q     <= y_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(MAX_SPRITES); i++) begin
            slot_idx_q[i] <= 6'd0;
            slot_x_q[i]   <= 8'd0;
            slot_row_q[i] <= 4'd0;
         end
      end else if (wr_en) begin
         slot_idx_q[count_q] <= idx_q;
         slot_x_q[count_q]   <= oam_rdata;
         slot_row_q[count_q] <= row;
      end
   end

   always_comb begin
      oam_addr = 8'd0;
      unique case (state_q)
         StReadY: oam_addr = {idx_q, 2'b00};
         StReadX: oam_addr = {idx_q, 2'b01};
         default: oam_addr = 8'd0;
      endcase
   end

   assign busy         = (state_q == StReadY) || (state_q == StReadX);
   assign done         = (state_q == StDone);
   assign sprite_count = count_q;

   always_comb begin
      slot_oam_idx = 6'd0;
      slot_x       = 8'd0;
      slot_row     = 4'd0;
      if (slot_sel < 4'(MAX_SPRITES)) begin
         slot_oam_idx = slot_idx_q[slot_sel];
         slot_x       = slot_x_q[slot_sel];
         slot_row     = slot_row_q[slot_sel];
      end
   end

endmodule

// File: tb/tb_oam_scan.sv
// Directed bench for oam_scan: behavioural OAM array, hand-computed sprite selections.
module tb_oam_scan;

   logic       clk;
   logic       reset;
   logic       lcd_en;
   logic       start;
   logic [7:0] ly;
   logic       obj_tall;
   logic [7:0] oam_addr;
   logic [7:0] oam_rdata;
   logic       busy;
   logic       done;
   logic [3:0] sprite_count;
   logic [3:0] slot_sel;
   logic [5:0] slot_oam_idx;
   logic [7:0] slot_x;
   logic [3:0] slot_row;

   logic [7:0] oam [160];
   int n_checks = 0;
   int n_pass   = 0;

   oam_scan #(
      .NUM_ENTRIES(40),
      .MAX_SPRITES(10)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .lcd_en       (lcd_en),
      .start        (start),
      .ly           (ly),
      .obj_tall     (obj_tall),
      .oam_addr     (oam_addr),
      .oam_rdata    (oam_rdata),
      .busy         (busy),
      .done         (done),
      .sprite_count (sprite_count),
      .slot_sel     (slot_sel),
      .slot_oam_idx (slot_oam_idx),
      .slot_x       (slot_x),
      .slot_row     (slot_row)
   );

   assign oam_rdata = (oam_addr < 8'd160) ? oam[oam_addr] : 8'hFF;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   // Y bytes all zero (never hit for ly<=143 with 8-px), X byte = 0x50+i.
   task automatic clear_oam();
      for (int i = 0; i < 40; i++) begin
         oam[4*i]   = 8'd0;
         oam[4*i+1] = 8'(8'h50 + i);
         oam[4*i+2] = 8'd0;
         oam[4*i+3] = 8'd0;
      end
   endtask

   task automatic check_slot(input logic [3:0] s, input logic [5:0] idx, input logic [7:0] x,
                             input logic [3:0] r);
      slot_sel = s;
      #1;
      check_eq("slot_oam_idx", slot_oam_idx, idx);
      check_eq("slot_x", slot_x, x);
      check_eq("slot_row", slot_row, r);
   endtask

   // Runs one scan from a start pulse; checks done latency, single-cycle pulse and
   // optionally busy and the address sequence. Scrambles ly/obj_tall mid-scan.
   task automatic run_scan(input logic [7:0] ly_v, input logic tall_v, input bit chk_addr,
                           input int stray_start);
      int cyc;
      bit seen;
      @(negedge clk);
      ly       = ly_v;
      obj_tall = tall_v;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc   = 1;
      seen  = 1'b0;
      while (cyc <= 200 && !seen) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            if (chk_addr && cyc <= 80) begin
               check_eq("oam_addr", oam_addr, 32'(((cyc - 1) / 2) * 4 + ((cyc - 1) % 2)));
               check_eq("busy_in_scan", busy, 1);
            end
            if (cyc == 5) begin
               ly       = ~ly_v;
               obj_tall = ~tall_v;
            end
            start = (cyc == stray_start);
            @(posedge clk);
            #1;
            cyc++;
         end
      end
      start = 1'b0;
      check_eq("done_cycle", seen ? cyc : 0, 81);
      check_eq("busy_at_done", busy, 0);
      @(posedge clk);
      #1;
      check_eq("done_one_cycle", done, 0);
   endtask

   initial begin
      int n_done;
      reset    = 1'b1;
      lcd_en   = 1'b1;
      start    = 1'b0;
      ly       = 8'd0;
      obj_tall = 1'b0;
      slot_sel = 4'd0;
      clear_oam();
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_count", sprite_count, 0);
      check_eq("rst_addr", oam_addr, 0);
      check_eq("rst_slot_x", slot_x, 0);
      @(negedge clk);
      reset = 1'b0;

      // Case 1 + case 6: basic 8-px search with full address sequence.
      oam[0] = 8'd16;
      oam[4] = 8'd9;
      oam[8] = 8'd8;
      oam[12] = 8'd24;
      run_scan(8'd0, 1'b0, 1'b1, 0);
      check_eq("c1_count", sprite_count, 2);
      check_slot(4'd0, 6'd0, 8'h50, 4'd0);
      check_slot(4'd1, 6'd1, 8'h51, 4'd7);

      // Case 2: tall sprites.
      clear_oam();
      oam[20] = 8'd12;
      oam[24] = 8'd28;
      run_scan(8'd10, 1'b1, 1'b0, 0);
      check_eq("c2_count", sprite_count, 1);
      check_slot(4'd0, 6'd5, 8'h55, 4'd14);

      // Case 4: boundary arithmetic near the bottom of the screen.
      clear_oam();
      oam[0] = 8'd159;
      oam[4] = 8'd160;
      oam[8] = 8'd152;
      run_scan(8'd143, 1'b0, 1'b0, 0);
      check_eq("c4_count", sprite_count, 2);
      check_slot(4'd0, 6'd0, 8'h50, 4'd0);
      check_slot(4'd1, 6'd2, 8'h52, 4'd7);

      // Y=255 must not wrap into a hit at ly=0.
      clear_oam();
      oam[0] = 8'd255;
      run_scan(8'd0, 1'b0, 1'b0, 0);
      check_eq("c4_wrap_count", sprite_count, 0);

      // Case 3: overflow; every entry hits, X = index.
      for (int i = 0; i < 40; i++) begin
         oam[4*i]   = 8'd16;
         oam[4*i+1] = 8'(i);
      end
      run_scan(8'd0, 1'b0, 1'b0, 0);
      check_eq("c3_count", sprite_count, 10);
      check_slot(4'd0, 6'd0, 8'd0, 4'd0);
      check_slot(4'd5, 6'd5, 8'd5, 4'd0);
      check_slot(4'd9, 6'd9, 8'd9, 4'd0);
      repeat (5) @(posedge clk);
      #1;
      check_slot(4'd7, 6'd7, 8'd7, 4'd0);
      check_eq("c3_persist_count", sprite_count, 10);

      // Case 5: abort at cycle 40, then restart with a stray start at cycle 20.
      @(negedge clk);
      ly    = 8'd0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (39) @(posedge clk);
      #1;
      check_eq("c5_count_pre_abort", sprite_count, 10);
      check_eq("c5_busy_pre_abort", busy, 1);
      lcd_en = 1'b0;
      @(posedge clk);
      #1;
      check_eq("c5_abort_busy", busy, 0);
      check_eq("c5_abort_count", sprite_count, 0);
      n_done = 0;
      for (int i = 0; i < 100; i++) begin
         if (done) n_done++;
         @(posedge clk);
         #1;
      end
      check_eq("c5_abort_no_done", n_done, 0);
      check_eq("c5_idle_busy", busy, 0);
      lcd_en = 1'b1;
      run_scan(8'd0, 1'b0, 1'b1, 20);
      check_eq("c5_restart_count", sprite_count, 10);

      // Asynchronous reset mid-scan.
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (30) @(posedge clk);
      #3;
      check_eq("mid_busy_pre_reset", busy, 1);
      reset = 1'b1;
      #1;
      check_eq("async_rst_busy", busy, 0);
      check_eq("async_rst_count", sprite_count, 0);
      check_eq("async_rst_addr", oam_addr, 0);
      slot_sel = 4'd3;
      #1;
      check_eq("async_rst_slot_x", slot_x, 0);
      @(negedge clk);
      reset = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/oam_scan.md
Name: oam_scan

Overview:
- Mode-2 sprite search stage that sits directly upstream of the mode-3 pixel fetcher/FIFO.
- On each scanline start it walks all 40 OAM entries at 2 cycles per entry (80 cycles total).
- It selects up to 10 sprites whose vertical span covers the current LY, in OAM order.
- It holds the selection in a small sprite buffer that the fetcher reads by slot index during mode 3.

Parameters:
- NUM_ENTRIES, 40, number of OAM entries scanned.
- MAX_SPRITES, 10, sprite buffer depth (per-line sprite limit).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- lcd_en  in  1  LCDC.7; low aborts the scan and clears results
- start  in  1  one-cycle pulse at mode-2 entry
- ly  in  8  current scanline, latched at start
- obj_tall  in  1  LCDC.2 (0 = 8-px sprites, 1 = 16-px sprites), latched at start
- oam_addr  out  8  OAM byte address
- oam_rdata  in  8  OAM byte at oam_addr, valid combinationally in the same cycle
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse when the scan is complete
- sprite_count  out  4  number of valid buffer slots (0..10)
- slot_sel  in  4  buffer slot queried by the fetcher
- slot_oam_idx  out  6  OAM entry index held in slot_sel
- slot_x  out  8  X byte held in slot_sel
- slot_row  out  4  row within the sprite for the latched LY (ly+16-Y)

Behaviour:
- Reset: all outputs 0, state IDLE, oam_addr 0, buffer cleared.
- State machine: IDLE, READ_Y, READ_X, DONE.
- IDLE:
  - start with lcd_en=1: latch ly and obj_tall, clear sprite_count, set entry i=0, go to READ_Y.
  - busy rises in the cycle after start.
- READ_Y:
  - oam_addr = 4*i; register Y = oam_rdata.
  - hit = (ly+16 >= Y) && (ly+16 < Y+H), where H = 16 if obj_tall else 8.
  - Evaluate in 9-bit unsigned arithmetic so Y+H and ly+16 never wrap.
  - Go to READ_X.
- READ_X:
  - oam_addr = 4*i+1.
  - If hit and sprite_count < MAX_SPRITES: write slot[sprite_count] = {i, oam_rdata, (ly+16-Y)[3:0]} and increment sprite_count in the same edge.
  - If i == NUM_ENTRIES-1, go to DONE; else i++ and go to READ_Y.
- DONE: done=1 for exactly one cycle, busy=0, go to IDLE.
- Timing: start sampled at edge 0; READ_Y for entry 0 is cycle 1; last READ_X is cycle 80; done is asserted in cycle 81.
- Selection rules:
  - X is not used for selection. X=0 or X>=168 sprites still consume a slot.
  - After 10 hits, later hits are discarded, but the scan still runs all 80 cycles.
- Slot read port:
  - Combinational from slot_sel.
  - slot_sel >= sprite_count returns stale or zero data; the consumer must gate on sprite_count.
  - Buffer contents persist after DONE until the next accepted start.
- Ignored start: while busy or in DONE, start is ignored.
- lcd_en falls at any state: next edge forces IDLE, sprite_count=0, busy=0, no done pulse.
- ly/obj_tall changes mid-scan have no effect (latched values only).
- Async reset mid-scan: immediate return to reset values.

Test Plan:
- Case 1, basic 8-px search:
  - Stimulus: ly=0, obj_tall=0, OAM Y={16,9,8,24,...}, rest Y=0.
  - Response: entries 0 and 1 selected; sprite_count=2; slot rows 0 and 7; done at cycle 81 after start; busy high for cycles 1..80.
- Case 2, tall sprites:
  - Stimulus: ly=10, obj_tall=1, entry 5 Y=12, entry 6 Y=28.
  - Response: entry 5 hits with row=14; entry 6 misses; sprite_count=1; slot 0 oam_idx=5.
- Case 3, per-line overflow:
  - Stimulus: all 40 entries Y=16, X=i, ly=0.
  - Response: sprite_count=10; slots hold indices 0..9 with X 0..9; scan still ends at cycle 80, done at 81.
- Case 4, boundary arithmetic:
  - Stimulus: ly=143, entry 0 Y=159, entry 1 Y=160, entry 2 Y=152; obj_tall=0.
  - Response: entries 0 and 2 hit (rows 0 and 7); entry 1 misses; no wrap on Y=255 (ly=0 miss).
- Case 5, abort and restart:
  - Stimulus: drop lcd_en at cycle 40, then raise it and pulse start.
  - Response: IDLE with sprite_count=0 and no done pulse; a re-start pulse gives a full 80-cycle scan.
  - Also: start pulsed at cycle 20 of a scan is ignored (done still at 81).
- Case 6, address sequence check:
  - Stimulus: any full scan.
  - Response: oam_addr sequence is 0,1,4,5,...,156,157 over cycles 1..80.
